seq_divider: RTL and testbench

Sequential restoring divider for unsigned operands. It is the inverse companion to the array multiplier datapath: it recovers quotient and remainder by shift-and-subtract, producing one quotient bit per clock. It sits beside the multiplier in the arithmetic unit and uses a start/busy/done handshake so that a controller can issue one division at a time.

---
 rtl/seq_divider.sv | 177 +++++++++++++++++
 tb/tb_seq_divider.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// seq_divider: sequential restoring divider for unsigned operands, one
// quotient bit per clock, with a start/busy/done handshake.
//
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous active-high reset; forces IDLE, clears outputs
//   start        request, sampled only in IDLE
//   dividend     unsigned dividend, captured on the accepted start
//   divisor      unsigned divisor, captured on the accepted start
//   busy         high while in RUN or DONE
//   done         one-cycle pulse when quotient/remainder are valid
//   quotient     unsigned quotient, held until replaced by the next result
//   remainder    unsigned remainder, held until replaced by the next result
//   div_by_zero  divisor was zero (only with DIV_ZERO_DETECT_EN)
//
// Optional feature macro: DIV_ZERO_DETECT_EN. When defined, a zero divisor
// bypasses RUN and reports all-ones / dividend with div_by_zero set one
// cycle after acceptance. When undefined, div_by_zero is tied to 0 and a
// zero divisor runs the normal algorithm.

module seq_divider #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   r_q, r_d;      // partial remainder (always < divisor)
  logic [WIDTH-1:0]   q_q, q_d;      // dividend shifting out / quotient in
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH:0]     r_sh;
  logic [WIDTH-1:0]   q_sh;
`ifdef DIV_ZERO_DETECT_EN
  logic               dz_q, dz_d;
  logic               pend_q, pend_d;  // zero-divisor result to load in DONE
`endif

  // State and datapath registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      q_q     <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
`ifdef DIV_ZERO_DETECT_EN
      dz_q    <= 1'b0;
      pend_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
`ifdef DIV_ZERO_DETECT_EN
      dz_q    <= dz_d;
      pend_q  <= pend_d;
`endif
    end
  end

  // Next-state and shift/subtract step
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    quo_d   = quo_q;
    rem_d   = rem_q;
`ifdef DIV_ZERO_DETECT_EN
    dz_d    = dz_q;
    pend_d  = pend_q;
`endif
    // Shift the next dividend bit into the (WIDTH+1)-bit partial remainder
    r_sh = {r_q, q_q[WIDTH-1]};
    q_sh = {q_q[WIDTH-2:0], 1'b0};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          dvs_d   = divisor;
          q_d     = dividend;
          r_d     = '0;
          cnt_d   = CNT_W'(WIDTH);
          busy_d  = 1'b1;
          state_d = S_RUN;
`ifdef DIV_ZERO_DETECT_EN
          dz_d    = 1'b0;
          if (divisor == '0) begin
            pend_d  = 1'b1;
            state_d = S_DONE;
          end
`endif
        end
      end
      S_RUN: begin
        if (r_sh >= {1'b0, dvs_q}) begin
          r_d = WIDTH'(r_sh - {1'b0, dvs_q});
          q_d = q_sh | WIDTH'(1);
        end else begin
          r_d = r_sh[WIDTH-1:0];
          q_d = q_sh;
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          quo_d   = q_d;
          rem_d   = r_d;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
`ifdef DIV_ZERO_DETECT_EN
        if (pend_q) begin
          // q_q still holds the untouched dividend
          quo_d  = '1;
          rem_d  = q_q;
          dz_d   = 1'b1;
          done_d = 1'b1;
          pend_d = 1'b0;
        end else begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
`else
        state_d = S_IDLE;
        busy_d  = 1'b0;
`endif
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;
`ifdef DIV_ZERO_DETECT_EN
  assign div_by_zero = dz_q;
`else
  assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider (WIDTH=4): arithmetic reference model with a
// per-cycle compare, plus directed vectors with literal expectations.
module tb_seq_divider;

  localparam int unsigned W = 4;
`ifdef DIV_ZERO_DETECT_EN
  localparam bit DZ = 1'b1;
`else
  localparam bit DZ = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int total = 0;
  int bad   = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start(start),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: results from / and %, timing from a cycle countdown
  int           m_cnt = 0;
  bit           m_in_done = 1'b0;
  logic         m_busy = 1'b0, m_done = 1'b0, m_dz = 1'b0, p_dz = 1'b0;
  logic [W-1:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_cnt = 0; m_in_done = 1'b0; m_busy = 1'b0; m_done = 1'b0;
      m_q = '0; m_r = '0; m_dz = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_in_done) begin
        m_in_done = 1'b0;
        m_busy = 1'b0;
      end else if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_q = p_q; m_r = p_r; m_dz = p_dz;
          m_done = 1'b1; m_in_done = 1'b1;
        end
      end else if (start) begin
        m_busy = 1'b1;
        m_dz = 1'b0;
        if (divisor == 0) begin
          p_q = '1; p_r = dividend; p_dz = DZ;
          m_cnt = DZ ? 1 : W;
        end else begin
          p_q = dividend / divisor; p_r = dividend % divisor; p_dz = 1'b0;
          m_cnt = W;
        end
      end
    end
  end

  // Per-cycle compare against the model
  always @(negedge clock) begin
    if (!reset) begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      chk("quotient", 32'(quotient), 32'(m_q));
      chk("remainder", 32'(remainder), 32'(m_r));
      chk("div_by_zero", 32'(div_by_zero), 32'(m_dz));
    end
  end

  // Present one start pulse; returns at the negedge after the accepting edge
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clock);
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Count cycles from the accepting edge until done is seen
  task automatic wait_done(output int lat, output int busy_cyc);
    lat = 0; busy_cyc = 0;
    if (busy) busy_cyc++;
    while (!done && lat < 40) begin
      @(negedge clock);
      lat++;
      if (busy) busy_cyc++;
    end
    if (lat >= 40) chk("done_timeout", 32'(lat), 32'(0));
    @(negedge clock);
    if (busy) busy_cyc++;
  endtask

  int lat, bcyc, cnt, t_prev, gap;

  initial begin
    #1 reset = 1'b1;
    repeat (2) @(negedge clock);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_quotient", 32'(quotient), 32'd0);
    chk("rst_remainder", 32'(remainder), 32'd0);
    reset = 1'b0;

    // Nominal 13/3
    issue(4'd13, 4'd3);
    wait_done(lat, bcyc);
    chk("nom_latency", 32'(lat), 32'd4);
    chk("nom_busy_cycles", 32'(bcyc), 32'd5);
    chk("nom_q", 32'(quotient), 32'd4);
    chk("nom_r", 32'(remainder), 32'd1);

    // Edge operands
    issue(4'd15, 4'd1);  wait_done(lat, bcyc);
    chk("15/1 q", 32'(quotient), 32'd15); chk("15/1 r", 32'(remainder), 32'd0);
    issue(4'd5, 4'd7);   wait_done(lat, bcyc);
    chk("5/7 q", 32'(quotient), 32'd0);   chk("5/7 r", 32'(remainder), 32'd5);
    issue(4'd0, 4'd9);   wait_done(lat, bcyc);
    chk("0/9 q", 32'(quotient), 32'd0);   chk("0/9 r", 32'(remainder), 32'd0);
    issue(4'd15, 4'd15); wait_done(lat, bcyc);
    chk("15/15 q", 32'(quotient), 32'd1); chk("15/15 r", 32'(remainder), 32'd0);

    // Divide by zero
    issue(4'd9, 4'd0);
    wait_done(lat, bcyc);
    chk("dz_latency", 32'(lat), DZ ? 32'd1 : 32'd4);
    chk("dz_q", 32'(quotient), 32'd15);
    chk("dz_r", 32'(remainder), 32'd9);

    // All non-zero-divisor pairs, checked by the model
    for (int a = 0; a < 16; a++)
      for (int b = 1; b < 16; b++) begin
        issue(W'(a), W'(b));
        wait_done(lat, bcyc);
      end

    // Start pulse during RUN is ignored
    issue(4'd13, 4'd3);
    @(negedge clock);
    start = 1'b1; dividend = 4'd12; divisor = 4'd5;
    @(negedge clock);
    start = 1'b0;
    wait_done(lat, bcyc);
    chk("ign_q", 32'(quotient), 32'd4);
    chk("ign_r", 32'(remainder), 32'd1);
    cnt = 0;
    repeat (8) begin @(negedge clock); if (done) cnt++; end
    chk("ign_no_extra_done", 32'(cnt), 32'd0);

    // Start held high: back-to-back every WIDTH+2 cycles
    @(negedge clock);
    start = 1'b1; dividend = 4'd13; divisor = 4'd3;
    cnt = 0; t_prev = 0;
    for (int c = 0; c < 40 && cnt < 3; c++) begin
      @(negedge clock);
      if (done) begin
        if (cnt > 0) begin
          gap = c - t_prev;
          chk("b2b_gap", 32'(gap), 32'd6);
        end
        t_prev = c;
        cnt++;
      end
    end
    chk("b2b_dones", 32'(cnt), 32'd3);
    start = 1'b0;
    repeat (3) @(negedge clock);

    // Reset mid-operation clears asynchronously, no done follows
    issue(4'd13, 4'd3);
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_q", 32'(quotient), 32'd0);
    chk("arst_r", 32'(remainder), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    cnt = 0;
    repeat (8) begin @(negedge clock); if (done) cnt++; end
    chk("arst_no_done", 32'(cnt), 32'd0);
    issue(4'd14, 4'd4);
    wait_done(lat, bcyc);
    chk("post_rst_q", 32'(quotient), 32'd3);
    chk("post_rst_r", 32'(remainder), 32'd2);

    // Results hold while operands change with start low
    issue(4'd7, 4'd2);
    wait_done(lat, bcyc);
    for (int i = 0; i < 10; i++) begin
      dividend = W'(i + 3); divisor = W'(15 - i);
      @(negedge clock);
      chk("hold_q", 32'(quotient), 32'd3);
      chk("hold_r", 32'(remainder), 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
